// File: rtl/vga_test_pkg.sv
// vga_test_pkg: default SVGA 800x600@60 timing, 12-bit colour constants,
// region decode and the colour-bar lookup shared by vga_sync_counter and
// vga_test_gen.
package vga_test_pkg;

    // SVGA 800x600@60 Hz, 40 MHz pixel clock
    localparam int SVGA_H_VISIBLE = 800;
    localparam int SVGA_H_FRONT   = 40;
    localparam int SVGA_H_SYNC    = 128;
    localparam int SVGA_H_BACK    = 88;
    localparam int SVGA_V_VISIBLE = 600;
    localparam int SVGA_V_FRONT   = 1;
    localparam int SVGA_V_SYNC    = 4;
    localparam int SVGA_V_BACK    = 23;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Position of a counter inside one line or one frame
    typedef enum logic [1:0] {
        REG_VIS  = 2'd0,
        REG_FP   = 2'd1,
        REG_SYNC = 2'd2,
        REG_BP   = 2'd3
    } region_t;

    localparam rgb_t WHITE   = 12'hFFF;
    localparam rgb_t YELLOW  = 12'hFF0;
    localparam rgb_t CYAN    = 12'h0FF;
    localparam rgb_t GREEN   = 12'h0F0;
    localparam rgb_t MAGENTA = 12'hF0F;
    localparam rgb_t RED     = 12'hF00;
    localparam rgb_t BLUE    = 12'h00F;
    localparam rgb_t BLACK   = 12'h000;

    // Regions run visible, front porch, sync, back porch
    function automatic region_t region_of(input int unsigned cnt,
                                          input int unsigned vis,
                                          input int unsigned fp,
                                          input int unsigned sp);
        if (cnt < vis)
            return REG_VIS;
        else if (cnt < vis + fp)
            return REG_FP;
        else if (cnt < vis + fp + sp)
            return REG_SYNC;
        else
            return REG_BP;
    endfunction

    // Classic colour-bar order, left to right
    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: horizontal/vertical position counters, region decode,
// sync generation (polarity applied), active-video flag and end-of-line /
// end-of-frame strobes. All outputs describe the current counter values and
// are combinational; the top registers them.
module vga_sync_counter
    import vga_test_pkg::*;
#(
    parameter int   H_VISIBLE_AREA = SVGA_H_VISIBLE,
    parameter int   H_FRONT_PORCH  = SVGA_H_FRONT,
    parameter int   H_SYNC_PULSE   = SVGA_H_SYNC,
    parameter int   H_BACK_PORCH   = SVGA_H_BACK,
    parameter int   V_VISIBLE_AREA = SVGA_V_VISIBLE,
    parameter int   V_FRONT_PORCH  = SVGA_V_FRONT,
    parameter int   V_SYNC_PULSE   = SVGA_V_SYNC,
    parameter int   V_BACK_PORCH   = SVGA_V_BACK,
    parameter logic HSYNC_POLARITY = 1'b0,
    parameter logic VSYNC_POLARITY = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    output logic h_sync,
    output logic v_sync,
    output logic active,
    output logic line_end,
    output logic frame_end
);

    localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    region_t       h_reg;
    region_t       v_reg;

    // Pixel and line counters; the line counter steps on each line wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Region decode and derived strobes for the current position
    always_comb begin
        h_reg     = region_of(32'(h_cnt), H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE);
        v_reg     = region_of(32'(v_cnt), V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE);
        h_sync    = HSYNC_POLARITY ^ (h_reg == REG_SYNC);
        v_sync    = VSYNC_POLARITY ^ (v_reg == REG_SYNC);
        active    = (h_reg == REG_VIS) && (v_reg == REG_VIS);
        line_end  = (h_cnt == H_LAST);
        frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

endmodule

// File: rtl/vga_test_gen.sv
// vga_test_gen: VGA test-pattern generator, eight vertical colour bars with
// registered RGB/HS/VS (one clock behind the position counters).
// Optional build macro VGA_TEST_LED_EN: when defined, LEDR shows a 10-bit
// frame counter; otherwise the counter is not built and LEDR is tied low.
module vga_test_gen
    import vga_test_pkg::*;
#(
    parameter int   H_VISIBLE_AREA = SVGA_H_VISIBLE,
    parameter int   H_FRONT_PORCH  = SVGA_H_FRONT,
    parameter int   H_SYNC_PULSE   = SVGA_H_SYNC,
    parameter int   H_BACK_PORCH   = SVGA_H_BACK,
    parameter int   V_VISIBLE_AREA = SVGA_V_VISIBLE,
    parameter int   V_FRONT_PORCH  = SVGA_V_FRONT,
    parameter int   V_SYNC_PULSE   = SVGA_V_SYNC,
    parameter int   V_BACK_PORCH   = SVGA_V_BACK,
    parameter logic HSYNC_POLARITY = 1'b0,
    parameter logic VSYNC_POLARITY = 1'b0
) (
    input  logic       VGA_CLK,
    input  logic       RESET_N,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [9:0] LEDR
);

    // Last bar absorbs the remainder of H_VISIBLE_AREA / 8
    localparam int BAR_W = H_VISIBLE_AREA / 8;
    localparam int BPW   = $clog2(BAR_W + 1);
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

    logic       h_sync;
    logic       v_sync;
    logic       active;
    logic       line_end;
    logic       frame_end;

    logic [BPW-1:0] bar_pos;
    logic [2:0]     bar_idx;
    rgb_t           rgb_q;
    logic           hs_q;
    logic           vs_q;

    vga_sync_counter #(
        .H_VISIBLE_AREA (H_VISIBLE_AREA),
        .H_FRONT_PORCH  (H_FRONT_PORCH),
        .H_SYNC_PULSE   (H_SYNC_PULSE),
        .H_BACK_PORCH   (H_BACK_PORCH),
        .V_VISIBLE_AREA (V_VISIBLE_AREA),
        .V_FRONT_PORCH  (V_FRONT_PORCH),
        .V_SYNC_PULSE   (V_SYNC_PULSE),
        .V_BACK_PORCH   (V_BACK_PORCH),
        .HSYNC_POLARITY (HSYNC_POLARITY),
        .VSYNC_POLARITY (VSYNC_POLARITY)
    ) u_sync (
        .clk       (VGA_CLK),
        .rst_n     (RESET_N),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .active    (active),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Bar index tracks h_cnt with a running position counter cleared at
    // line start, so no divider is needed; it parks on the last bar
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (line_end) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_idx != 3'd7) begin
            if (bar_pos == BAR_LAST) begin
                bar_pos <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pos <= bar_pos + 1'b1;
            end
        end
    end

    // Output registers: colour and syncs stay aligned, sync idles inactive
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rgb_q <= BLACK;
            hs_q  <= HSYNC_POLARITY;
            vs_q  <= VSYNC_POLARITY;
        end else begin
            rgb_q <= active ? bar_color(bar_idx) : BLACK;
            hs_q  <= h_sync;
            vs_q  <= v_sync;
        end
    end

    assign VGA_R  = rgb_q.r;
    assign VGA_G  = rgb_q.g;
    assign VGA_B  = rgb_q.b;
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;

`ifdef VGA_TEST_LED_EN
    logic [9:0] frame_cnt;

    // Completed-frame count, wraps naturally at 1023 -> 0
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N)
            frame_cnt <= '0;
        else if (frame_end)
            frame_cnt <= frame_cnt + 10'd1;
    end

    assign LEDR = frame_cnt;
`else
    assign LEDR = 10'b0;
`endif

endmodule

// File: tb/tb_vga_test_gen.sv
// tb_vga_test_gen: dut_a runs default SVGA timing (line-level checks),
// dut_b runs a shrunken frame with inverted sync polarity and randomly
// placed resets (frame-level and frame-counter checks). Every cycle both
// DUTs are compared with a model that derives position from elapsed clocks.
module tb_vga_test_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic       a_hs, a_vs, b_hs, b_vs;
    logic [9:0] a_led, b_led;

    vga_test_gen dut_a (
        .VGA_CLK (clk), .RESET_N (rst_a),
        .VGA_R (a_r), .VGA_G (a_g), .VGA_B (a_b),
        .VGA_HS (a_hs), .VGA_VS (a_vs), .LEDR (a_led)
    );

    vga_test_gen #(
        .H_VISIBLE_AREA (43), .H_FRONT_PORCH (3), .H_SYNC_PULSE (6), .H_BACK_PORCH (4),
        .V_VISIBLE_AREA (6),  .V_FRONT_PORCH (1), .V_SYNC_PULSE (2), .V_BACK_PORCH (3),
        .HSYNC_POLARITY (1'b1), .VSYNC_POLARITY (1'b1)
    ) dut_b (
        .VGA_CLK (clk), .RESET_N (rst_b),
        .VGA_R (b_r), .VGA_G (b_g), .VGA_B (b_b),
        .VGA_HS (b_hs), .VGA_VS (b_vs), .LEDR (b_led)
    );

    localparam int B_FRAME = 56 * 12;

    logic [11:0] colours [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    int vectors    = 0;
    int miscompares = 0;
    int ka = 0, kb = 0;
    int rise1 = -1, rise2 = -1, hs_w = 0;
    logic a_hs_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {LEDR, HS, VS, RGB} after k edges since reset release
    function automatic logic [23:0] model(input int k,
                                          input int hv, input int hf, input int hs, input int hb,
                                          input int vv, input int vf, input int vs, input int vb,
                                          input logic hp, input logic vp);
        int n, ht, vt, h, v, idx;
        logic [11:0] rgb;
        logic [9:0]  led;
        logic        hsx, vsx;
        if (k == 0) return {10'd0, hp, vp, 12'h000};
        n   = k - 1;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        h   = n % ht;
        v   = (n / ht) % vt;
        idx = h / (hv / 8);
        if (idx > 7) idx = 7;
        rgb = (h < hv && v < vv) ? colours[idx] : 12'h000;
        hsx = hp ^ (h >= hv + hf && h < hv + hf + hs);
        vsx = vp ^ (v >= vv + vf && v < vv + vf + vs);
`ifdef VGA_TEST_LED_EN
        led = 10'((k / (ht * vt)) % 1024);
`else
        led = 10'd0;
`endif
        return {led, hsx, vsx, rgb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_a) ka++;
        if (rst_b) kb++;
        chk($sformatf("a_k%0d", ka), {a_led, a_hs, a_vs, a_r, a_g, a_b},
            model(ka, 800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0));
        chk($sformatf("b_k%0d", kb), {b_led, b_hs, b_vs, b_r, b_g, b_b},
            model(kb, 43, 3, 6, 4, 6, 1, 2, 3, 1'b1, 1'b1));
        if (ka > 0) begin
            if (a_hs && !a_hs_prev) begin
                if (rise1 < 0) rise1 = ka - 1;
                else if (rise2 < 0) rise2 = ka - 1;
            end
            if (a_hs && ka - 1 < 1056) hs_w++;
        end
        a_hs_prev = a_hs;
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) step();
        rst_a = 1'b1;
        rst_b = 1'b1;
        // restart dut_b at random points mid-frame
        for (int s = 0; s < 3; s++) begin
            repeat ($urandom_range(40, 700)) step();
            rst_b = 1'b0;
            kb    = 0;
            repeat ($urandom_range(1, 3)) step();
            rst_b = 1'b1;
        end
        repeat (3 * B_FRAME) step();
`ifdef VGA_TEST_LED_EN
        chk("ledr_3frames", 32'(b_led), 32'd3);
`else
        chk("ledr_3frames", 32'(b_led), 32'd0);
`endif
        repeat (200) step();
        chk("hs_start",  32'(rise1), 32'd840);
        chk("hs_width",  32'(hs_w), 32'd128);
        chk("hs_period", 32'(rise2 - rise1), 32'd1056);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_test_gen.md
# vga_test_gen

VGA test-pattern generator for the DE10-Lite. It produces HSYNC/VSYNC timing and 4-bit-per-channel RGB from one pixel clock, and drives eight vertical colour bars. The default timing is SVGA 800x600@60 Hz at a 40 MHz pixel clock. It sits directly on the board VGA pins and LEDs as a bring-up/driver smoke test.

## Interface
- Reset is asynchronous, active-low; one clock (`VGA_CLK`).
- `H_VISIBLE_AREA`, 800, visible pixels per line
- `H_FRONT_PORCH`, 40, pixels
- `H_SYNC_PULSE`, 128, pixels
- `H_BACK_PORCH`, 88, pixels
- `V_VISIBLE_AREA`, 600, visible lines per frame
- `V_FRONT_PORCH`, 1, lines
- `V_SYNC_PULSE`, 4, lines
- `V_BACK_PORCH`, 23, lines
- `HSYNC_POLARITY`, 1'b0: 0 = positive pulse (idle low, high in sync); 1 = negative pulse (idle high, low in sync)
- `VSYNC_POLARITY`, 1'b0, same encoding for VSYNC
- `VGA_CLK` in 1: pixel clock, rising edge
- `RESET_N` in 1: async active-low reset
- `VGA_R` out 4: red
- `VGA_G` out 4: green
- `VGA_B` out 4: blue
- `VGA_HS` out 1: horizontal sync
- `VGA_VS` out 1: vertical sync
- `LEDR` out 10: frame counter

## Operation
- H_TOTAL = sum of the four H parameters (1056). V_TOTAL = sum of the four V parameters (628).
- `h_cnt` runs 0..H_TOTAL-1 and increments every clock. On wrap to 0, `v_cnt` increments. `v_cnt` runs 0..V_TOTAL-1 and wraps to 0.
- Horizontal regions:
  - visible: [0, H_VIS-1]
  - front porch: [H_VIS, H_VIS+H_FP-1]
  - sync: [H_VIS+H_FP, H_VIS+H_FP+H_SP-1] (840..967 by default)
  - back porch: rest
- Vertical regions are the same order. Sync is lines 601..604 by default.
- HS = `HSYNC_POLARITY` XOR (h in sync region). VS = `VSYNC_POLARITY` XOR (v in sync region).
- Active = h < H_VIS and v < V_VIS. Outside active, RGB = 0.
- Bars:
  - BAR_W = H_VIS/8 (integer; the last bar absorbs the remainder).
  - Bar index 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is 4'hF or 4'h0.
- Bar index comes from a running counter reset at h=0, not a divider.
- Frame counter: 10-bit. Increments when h=H_TOTAL-1 and v=V_TOTAL-1; wraps 1023->0.

## Timing
- All outputs are registered.
- Outputs at edge k reflect counter values (h,v) from cycle k-1: one-cycle latency, with HS, VS and RGB aligned to each other.
- Reset (async, while `RESET_N`=0):
  - counters = 0, frame counter = 0
  - RGB = 0, LEDR = 0
  - HS = `HSYNC_POLARITY`, VS = `VSYNC_POLARITY` (inactive)
- First rising edge after release outputs pixel (0,0): white.
- Reset mid-frame restarts at (0,0) with no partial-line recovery.
- Frame period = H_TOTAL*V_TOTAL = 663,168 clocks = 16,579,200 ns at 40 MHz.
- Line = 1056 clocks.

## Configuration
- `VGA_TEST_LED_EN`:
  - Defined: LEDR shows the frame counter.
  - Undefined: the frame counter is not built and LEDR is tied to 10'b0.
- Timing and pattern are unaffected either way.

## Structure
- Package `vga_test_pkg`:
  - SVGA 800x600@60 default timing constants
  - 12-bit colour constants (WHITE..BLACK)
  - bar-colour lookup function
- Sub-module `vga_sync_counter`: h/v counters, region decode, HS/VS generation, active flag, end-of-frame strobe.
- Top: bar counter, colour lookup, output registers, optional frame counter.

## Test plan
- Reset held, then released:
  - while held: RGB=0, HS=0, VS=0 (default polarity), LEDR=0
  - first edge after release: RGB=FFF (white)
- Line timing:
  - HS high for exactly 128 clocks, starting 840 clocks after line start
  - HS period 1056 clocks
  - RGB=0 for pixels 800..1055
- Bars on line 0:
  - pixel 0 white, 100 yellow, 199 yellow, 200 cyan, 700 black
- Frame timing:
  - VS high for 4 lines (4224 clocks), starting at line 601
  - frame period 663,168 clocks (16,579,200 ns at 25 ns clock)
- With `HSYNC_POLARITY` = `VSYNC_POLARITY` = 1: HS/VS idle high and pulse low at the same positions.
- With `VGA_TEST_LED_EN` defined: after 3 full frames, LEDR=3. With the macro undefined, LEDR stays 0.
